fp_minmax_stream_reducer: RTL

- Consumes a packetised stream of IEEE-754 single-precision operands over a valid/ready handshake.
- Tracks the running minimum, running maximum and element count for each packet.
- Presents one result beat per packet on an output valid/ready handshake.
- Sits downstream of the FP register-read path in the Floating ALU and implements packet-level FMIN/FMAX reduction.

---
 rtl/fp_minmax_stream_reducer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fp_minmax_stream_reducer.sv
// Packet-level FMIN/FMAX reduction over a valid/ready stream of binary32 operands.
// Optional macro FMINMAX_NAN_EN: RISC-V style NaN handling (NaNs skipped, out_nan flag).
module fp_minmax_stream_reducer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             En,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_min,
    output logic [XLEN-1:0]  out_max,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Monotone unsigned key: -0 sorts below +0 and infinities land at the ends.
    function automatic logic [31:0] order_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

`ifdef FMINMAX_NAN_EN
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    logic empty_r;
    logic empty_s;
`endif

    state_t           state_r;
    state_t           state_s;
    logic             accept_s;
    logic             first_s;
    logic [XLEN-1:0]  min_s;
    logic [XLEN-1:0]  max_s;
    logic [CNT_W-1:0] count_s;
    logic             nan_s;
    logic             valid_s;

    assign in_ready = rst_n && En && (state_r != HOLD);
    assign accept_s = in_valid && in_ready;
    assign first_s  = (state_r == IDLE);

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a low En freezes the machine.
    always_comb begin
        state_s = state_r;
        if (En) begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (accept_s) begin
                        state_s = in_last ? HOLD : ACCUM;
                    end else begin
                        state_s = state_r;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: state_s = IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Running min/max/count/NaN update for an accepted beat, and result-valid tracking.
    always_comb begin
        min_s   = out_min;
        max_s   = out_max;
        count_s = out_count;
        nan_s   = out_nan;
        valid_s = out_valid;
`ifdef FMINMAX_NAN_EN
        empty_s = empty_r;
`endif
        if (En && accept_s) begin
            valid_s = in_last;
            if (first_s) begin
                count_s = CNT_ONE;
            end else if (out_count != CNT_MAX) begin
                count_s = out_count + CNT_ONE;
            end else begin
                count_s = CNT_MAX;
            end
`ifdef FMINMAX_NAN_EN
            // While no ordered value has been seen, min/max park at the canonical NaN.
            nan_s   = (first_s ? 1'b0 : out_nan) | is_nan(in_data);
            empty_s = first_s ? 1'b1 : empty_r;
            if (first_s) begin
                min_s = CANON_NAN;
                max_s = CANON_NAN;
            end else begin
                min_s = out_min;
                max_s = out_max;
            end
            if (is_nan(in_data)) begin
                empty_s = empty_s;
            end else if (empty_s) begin
                min_s   = in_data;
                max_s   = in_data;
                empty_s = 1'b0;
            end else begin
                if (order_key(in_data) < order_key(out_min)) begin
                    min_s = in_data;
                end else begin
                    min_s = out_min;
                end
                if (order_key(in_data) > order_key(out_max)) begin
                    max_s = in_data;
                end else begin
                    max_s = out_max;
                end
            end
`else
            nan_s = 1'b0;
            if (first_s) begin
                min_s = in_data;
                max_s = in_data;
            end else begin
                if (order_key(in_data) < order_key(out_min)) begin
                    min_s = in_data;
                end else begin
                    min_s = out_min;
                end
                if (order_key(in_data) > order_key(out_max)) begin
                    max_s = in_data;
                end else begin
                    max_s = out_max;
                end
            end
`endif
        end else if (En && (state_r == HOLD) && out_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = out_valid;
        end
    end

    // Result registers drive the output ports directly.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_min   <= 32'h0000_0000;
            out_max   <= 32'h0000_0000;
            out_count <= {CNT_W{1'b0}};
            out_nan   <= 1'b0;
        end else begin
            out_valid <= valid_s;
            out_min   <= min_s;
            out_max   <= max_s;
            out_count <= count_s;
            out_nan   <= nan_s;
        end
    end

`ifdef FMINMAX_NAN_EN
    // Tracks whether the current packet has produced an ordered (non-NaN) value yet.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            empty_r <= 1'b1;
        end else begin
            empty_r <= empty_s;
        end
    end
`endif

endmodule
